// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: error-metric collector for N-bit approximate adders.
// Latency: 2-stage pipeline (S1 exact/ED, S2 statistics), results final 2 cycles after last transfer.
// Backpressure: in_ready_o high for the whole RUN state, never stalls mid-run.
// Optional feature: define APPROX_ERRMON_LFSR_EN for on-chip LFSR operand generation (a_o/b_o).
module approx_adder_err_monitor #(
  parameter int N     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_samples_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic [N-1:0]     approx_sum_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] zero_cnt_o,
  output logic [ACC_W-1:0] sum_ed_o,
  output logic [N-1:0]     max_ed_o
`ifdef APPROX_ERRMON_LFSR_EN
  ,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic             r_s1_vld;
  logic [N-1:0]     r_s1_exact;
  logic [N-1:0]     r_s1_ed;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_zero_cnt;
  logic [ACC_W-1:0] r_sum_ed;
  logic [N-1:0]     r_max_ed;

  logic             w_start_acc;
  logic             w_xfer;
  logic             w_last;
  logic [N-1:0]     w_op_a;
  logic [N-1:0]     w_op_b;
  logic [N-1:0]     w_exact;
  logic [N-1:0]     w_ed;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_sum_nxt;

  // start is only honoured when no run is in flight
  assign w_start_acc = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer      = in_valid_i && (r_state == S_RUN);
  assign w_last      = w_xfer && ((r_xfer_cnt + CNT_W'(1)) == r_num);

`ifdef APPROX_ERRMON_LFSR_EN
  logic [N-1:0] r_lfsr_a;
  logic [N-1:0] r_lfsr_b;

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] v);
    return {v[N-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // operand generators: reseed on an accepted start, step once per transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr_a <= N'(16'hACE1);
      r_lfsr_b <= N'(16'h1D2B);
    end else if (w_start_acc) begin
      r_lfsr_a <= N'(16'hACE1);
      r_lfsr_b <= N'(16'h1D2B);
    end else if (w_xfer) begin
      r_lfsr_a <= lfsr_step(r_lfsr_a);
      r_lfsr_b <= lfsr_step(r_lfsr_b);
    end
  end

  assign a_o    = r_lfsr_a;
  assign b_o    = r_lfsr_b;
  assign w_op_a = r_lfsr_a;
  assign w_op_b = r_lfsr_b;
`else
  assign w_op_a = a_i;
  assign w_op_b = b_i;
`endif

  // carry-out is dropped on purpose: the approximate adder is judged on N bits only
  assign w_exact = w_op_a + w_op_b;
  assign w_ed    = (approx_sum_i >= w_exact) ? (approx_sum_i - w_exact)
                                             : (w_exact - approx_sum_i);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic; DRAIN leaves once S1 no longer holds a sample
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) w_state_nxt = (num_samples_i == '0) ? S_DONE : S_RUN;
      S_RUN:          if (w_last)  w_state_nxt = S_DRAIN;
      S_DRAIN:        if (!r_s1_vld) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // run length latch and transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num      <= '0;
      r_xfer_cnt <= '0;
    end else if (w_start_acc) begin
      r_num      <= num_samples_i;
      r_xfer_cnt <= '0;
    end else if (w_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  // S1: register exact sum and error distance of each transferred sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_exact <= '0;
      r_s1_ed    <= '0;
    end else begin
      r_s1_vld <= w_xfer && !w_start_acc;
      if (w_xfer) begin
        r_s1_exact <= w_exact;
        r_s1_ed    <= w_ed;
      end
    end
  end

  assign w_sum_ext = {1'b0, r_sum_ed} + {{(ACC_W + 1 - N){1'b0}}, r_s1_ed};
  assign w_sum_nxt = w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];

  // S2: fold the S1 sample into the running statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_zero_cnt   <= '0;
      r_sum_ed     <= '0;
      r_max_ed     <= '0;
    end else if (w_start_acc) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_zero_cnt   <= '0;
      r_sum_ed     <= '0;
      r_max_ed     <= '0;
    end else if (r_s1_vld) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      r_err_cnt    <= r_err_cnt + {{(CNT_W-1){1'b0}}, (r_s1_ed != '0)};
      r_zero_cnt   <= r_zero_cnt + {{(CNT_W-1){1'b0}}, (r_s1_exact == '0)};
      r_sum_ed     <= w_sum_nxt;
      if (r_s1_ed > r_max_ed) r_max_ed <= r_s1_ed;
    end
  end

  assign in_ready_o   = (r_state == S_RUN);
  assign busy_o       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o       = (r_state == S_DONE);
  assign sample_cnt_o = r_sample_cnt;
  assign err_cnt_o    = r_err_cnt;
  assign zero_cnt_o   = r_zero_cnt;
  assign sum_ed_o     = r_sum_ed;
  assign max_ed_o     = r_max_ed;

endmodule
